// File: rtl/axi_pkg.sv
// Shared AXI definitions for the SRAM slave: response and burst encodings,
// controller state type, and the per-beat address step.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    RD_RESP,
    WR_DATA,
    WR_RESP
  } state_e;

  // WRAP is stepped like INCR; wrap boundaries are not modelled.
  function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                            input logic [2:0]  size,
                                            input logic [1:0]  burst);
    logic [31:0] step;
    step = 32'd1 << size;
    if (burst == BURST_FIXED) return addr;
    return addr + step;
  endfunction

endpackage

// File: rtl/axi_addr_gen.sv
// Burst address generator shared by the read and write paths: holds the
// current beat address and remaining beat count, and flags illegal requests.
module axi_addr_gen
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  load,
  input  logic                  advance,
  input  logic [31:0]           addr_in,
  input  logic [7:0]            len_in,
  input  logic [2:0]            size_in,
  input  logic [1:0]            burst_in,
  output logic [ADDR_WIDTH-1:0] word_addr,
  output logic                  last,
  output logic                  err
);

  logic [31:0] addr_q, addr_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  burst_q, burst_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;

  // The error is judged once from the request and then held for every beat.
  always_comb begin
    addr_d  = addr_q;
    size_d  = size_q;
    burst_d = burst_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (load) begin
      addr_d  = addr_in;
      size_d  = size_in;
      burst_d = burst_in;
      cnt_d   = len_in;
      err_d   = (addr_in[31:ADDR_WIDTH+2] != '0) || (len_in > 8'd15) ||
                (size_in > 3'd2);
    end else if (advance) begin
      addr_d = next_addr(addr_q, size_q, burst_q);
      cnt_d  = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr_q  <= '0;
      size_q  <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign word_addr = addr_q[ADDR_WIDTH+1:2];
  assign last      = (cnt_q == 8'd0);
  assign err       = err_q;

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave serving one read or write burst at a time from a single-port
// synchronous SRAM with one cycle of read latency.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned ID_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [ID_WIDTH-1:0]   arid,
  input  logic [31:0]           araddr,
  input  logic [7:0]            arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [ID_WIDTH-1:0]   rid,
  output logic [31:0]           rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready,
  input  logic [ID_WIDTH-1:0]   awid,
  input  logic [31:0]           awaddr,
  input  logic [7:0]            awlen,
  input  logic [2:0]            awsize,
  input  logic [1:0]            awburst,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ID_WIDTH-1:0]   wid,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wstrb,
  input  logic                  wlast,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [ID_WIDTH-1:0]   bid,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  output logic                  ram_en,
  output logic [3:0]            ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata
);

  state_e                state_q, state_d;
  logic                  rr_q, rr_d;  // 1: read wins a simultaneous request
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  wr_err_q, wr_err_d;

  logic                  ag_load, ag_advance, ag_last, ag_err;
  logic [ADDR_WIDTH-1:0] ag_word_addr;
  logic [31:0]           ld_addr;
  logic [7:0]            ld_len;
  logic [2:0]            ld_size;
  logic [1:0]            ld_burst;

  logic                  unused_wid;
  assign unused_wid = ^wid;

  axi_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
    .clk      (clk),
    .resetn   (resetn),
    .load     (ag_load),
    .advance  (ag_advance),
    .addr_in  (ld_addr),
    .len_in   (ld_len),
    .size_in  (ld_size),
    .burst_in (ld_burst),
    .word_addr(ag_word_addr),
    .last     (ag_last),
    .err      (ag_err)
  );

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    id_d       = id_q;
    rdata_d    = rdata_q;
    wr_err_d   = wr_err_q;
    arready    = 1'b0;
    awready    = 1'b0;
    wready     = 1'b0;
    rvalid     = 1'b0;
    bvalid     = 1'b0;
    ram_en     = 1'b0;
    ram_we     = '0;
    ram_wdata  = '0;
    ag_load    = 1'b0;
    ag_advance = 1'b0;
    ld_addr    = awaddr;
    ld_len     = awlen;
    ld_size    = awsize;
    ld_burst   = awburst;
    unique case (state_q)
      IDLE: begin
        awready = awvalid & (~arvalid | ~rr_q);
        arready = arvalid & (~awvalid | rr_q);
        if (awready) begin
          ag_load  = 1'b1;
          id_d     = awid;
          wr_err_d = 1'b0;
          state_d  = WR_DATA;
        end else if (arready) begin
          ag_load  = 1'b1;
          id_d     = arid;
          ld_addr  = araddr;
          ld_len   = arlen;
          ld_size  = arsize;
          ld_burst = arburst;
          state_d  = RD_REQ;
        end
      end
      RD_REQ: begin
        ram_en  = ~ag_err;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        rdata_d = ag_err ? '0 : ram_rdata;
        state_d = RD_RESP;
      end
      RD_RESP: begin
        rvalid = 1'b1;
        if (rready) begin
          if (ag_last) begin
            state_d = IDLE;
            rr_d    = ~rr_q;
          end else begin
            ag_advance = 1'b1;
            state_d    = RD_REQ;
          end
        end
      end
      WR_DATA: begin
        wready = 1'b1;
        if (wvalid) begin
          ram_en    = ~ag_err;
          ram_we    = ag_err ? 4'b0000 : wstrb;
          ram_wdata = wdata;
          if (wlast != ag_last) wr_err_d = 1'b1;
          if (ag_last) state_d = WR_RESP;
          else         ag_advance = 1'b1;
        end
      end
      WR_RESP: begin
        bvalid = 1'b1;
        if (bready) begin
          state_d = IDLE;
          rr_d    = ~rr_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      id_q     <= '0;
      rdata_q  <= '0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      id_q     <= id_d;
      rdata_q  <= rdata_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign rid      = id_q;
  assign rdata    = rdata_q;
  assign rresp    = (rvalid && ag_err) ? RESP_SLVERR : RESP_OKAY;
  assign rlast    = rvalid & ag_last;
  assign bid      = id_q;
  assign bresp    = (bvalid && (ag_err || wr_err_q)) ? RESP_SLVERR : RESP_OKAY;
  assign ram_addr = ag_word_addr;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: a behavioural SRAM, directed AXI stimulus
// that queues expected R/B responses, and a monitor that checks each handshake.
module tb_axi_sram_slave;
  import axi_pkg::*;

  localparam int unsigned AW = 16;
  localparam int unsigned IW = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic [IW-1:0] arid, rid, awid, wid, bid;
  logic [31:0]   araddr, awaddr, rdata, wdata, ram_wdata, ram_rdata;
  logic [7:0]    arlen, awlen;
  logic [2:0]    arsize, awsize;
  logic [1:0]    arburst, awburst, rresp, bresp;
  logic          arvalid, arready, rlast, rvalid, rready;
  logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]    wstrb, ram_we;
  logic          ram_en;
  logic [AW-1:0] ram_addr;

  logic [31:0]   mem [0:(1<<AW)-1];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [31:0]   pre_data = '0;
  int            ram_en_cnt = 0;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {logic [IW-1:0] id; logic [31:0] data; logic [1:0] resp; logic last;} r_exp_t;
  typedef struct packed {logic [IW-1:0] id; logic [1:0] resp;} b_exp_t;
  r_exp_t exp_r[$];
  b_exp_t exp_b[$];

  axi_sram_slave #(.ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
    .clk(clk), .resetn(resetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_en) begin
      ram_en_cnt <= ram_en_cnt + 1;
      if (ram_we == 4'b0000) ram_rdata <= mem[ram_addr];
      else for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    r_exp_t er;
    b_exp_t eb;
    forever begin
      @(negedge clk);
      if (resetn && rvalid && rready) begin
        chk("r_expected", 32'(exp_r.size() != 0), 32'd1);
        if (exp_r.size() != 0) begin
          er = exp_r.pop_front();
          chk("rid",   32'(rid),   32'(er.id));
          chk("rdata", rdata,      er.data);
          chk("rresp", 32'(rresp), 32'(er.resp));
          chk("rlast", 32'(rlast), 32'(er.last));
        end
      end
      if (resetn && bvalid && bready) begin
        chk("b_expected", 32'(exp_b.size() != 0), 32'd1);
        if (exp_b.size() != 0) begin
          eb = exp_b.pop_front();
          chk("bid",   32'(bid),   32'(eb.id));
          chk("bresp", 32'(bresp), 32'(eb.resp));
        end
      end
    end
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      0:       return rvalid;
      1:       return bvalid;
      2:       return arready;
      3:       return awready;
      default: return wready;
    endcase
  endfunction

  task automatic wait_hi(input int sel, input string name);
    logic v;
    v = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      v = pick(sel);
      if (v) break;
    end
    chk(name, 32'(v), 32'd1);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
    pre_addr = a; pre_data = d; pre_we = 1'b1;
    @(posedge clk); #1 pre_we = 1'b0;
  endtask

  task automatic push_r(input logic [IW-1:0] id, input logic [31:0] d, input logic [1:0] resp, input logic last);
    exp_r.push_back('{id: id, data: d, resp: resp, last: last});
  endtask

  task automatic push_b(input logic [IW-1:0] id, input logic [1:0] resp);
    exp_b.push_back('{id: id, resp: resp});
  endtask

  task automatic ar_hs(input logic [IW-1:0] id, input logic [31:0] a, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    arid = id; araddr = a; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    wait_hi(2, "arready");
    @(posedge clk); #1 arvalid = 1'b0;
  endtask

  task automatic aw_hs(input logic [IW-1:0] id, input logic [31:0] a, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    awid = id; awaddr = a; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    wait_hi(3, "awready");
    @(posedge clk); #1 awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    wait_hi(4, "wready");
    @(posedge clk); #1 wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      if (exp_r.size() == 0 && exp_b.size() == 0) break;
      @(negedge clk);
    end
    chk("drain", 32'(exp_r.size() + exp_b.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0;
    resetn = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    rready = 1'b1; bready = 1'b1;
    fork monitor(); join_none

    preload(16'd4, 32'hDEADBEEF);
    preload(16'd8, 32'hAABBCCDD);
    @(posedge clk); #1;
    chk("rst_arready", 32'(arready), 0);
    chk("rst_awready", 32'(awready), 0);
    chk("rst_rvalid",  32'(rvalid),  0);
    chk("rst_bvalid",  32'(bvalid),  0);
    chk("rst_ram_en",  32'(ram_en),  0);
    chk("rst_ram_we",  32'(ram_we),  0);
    chk("rst_wready",  32'(wready),  0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // single read with latency checks
    push_r(4'd3, 32'hDEADBEEF, RESP_OKAY, 1'b1);
    ar_hs(4'd3, 32'h10, 8'd0, 3'd2, BURST_INCR);
    chk("lat_t1_ram_en", 32'(ram_en), 1);
    chk("lat_t1_ram_we", 32'(ram_we), 0);
    chk("lat_t1_addr", 32'(ram_addr), 32'd4);
    chk("lat_t1_rvalid", 32'(rvalid), 0);
    @(posedge clk); #1;
    chk("lat_t2_ram_en", 32'(ram_en), 0);
    chk("lat_t2_rvalid", 32'(rvalid), 0);
    @(posedge clk); #1;
    chk("lat_t3_rvalid", 32'(rvalid), 1);
    drain();

    // byte strobe write then read back
    push_b(4'd1, RESP_OKAY);
    aw_hs(4'd1, 32'h20, 8'd0, 3'd2, BURST_INCR);
    w_beat(32'h00001200, 4'b0010, 1'b1);
    drain();
    push_r(4'd2, 32'hAABB12DD, RESP_OKAY, 1'b1);
    ar_hs(4'd2, 32'h20, 8'd0, 3'd2, BURST_INCR);
    drain();

    // 4-beat INCR write burst, then read burst
    push_b(4'd4, RESP_OKAY);
    aw_hs(4'd4, 32'h20, 8'd3, 3'd2, BURST_INCR);
    w_beat(32'h11, 4'hF, 1'b0);
    w_beat(32'h22, 4'hF, 1'b0);
    w_beat(32'h33, 4'hF, 1'b0);
    w_beat(32'h44, 4'hF, 1'b1);
    drain();
    push_r(4'd5, 32'h11, RESP_OKAY, 1'b0);
    push_r(4'd5, 32'h22, RESP_OKAY, 1'b0);
    push_r(4'd5, 32'h33, RESP_OKAY, 1'b0);
    push_r(4'd5, 32'h44, RESP_OKAY, 1'b1);
    ar_hs(4'd5, 32'h20, 8'd3, 3'd2, BURST_INCR);
    drain();

    // byte-size INCR: four beats stay inside word 4
    for (int i = 0; i < 4; i++) push_r(4'd6, 32'hDEADBEEF, RESP_OKAY, i == 3);
    ar_hs(4'd6, 32'h10, 8'd3, 3'd0, BURST_INCR);
    drain();

    // FIXED burst: both beats hit word 0x10
    push_b(4'd6, RESP_OKAY);
    aw_hs(4'd6, 32'h40, 8'd1, 3'd2, BURST_FIXED);
    w_beat(32'hA1, 4'hF, 1'b0);
    w_beat(32'hB2, 4'hF, 1'b1);
    drain();
    push_r(4'd7, 32'hB2, RESP_OKAY, 1'b0);
    push_r(4'd7, 32'hB2, RESP_OKAY, 1'b1);
    ar_hs(4'd7, 32'h40, 8'd1, 3'd2, BURST_FIXED);
    drain();

    // early wlast -> SLVERR, beat count still from awlen
    push_b(4'd7, RESP_SLVERR);
    aw_hs(4'd7, 32'h48, 8'd1, 3'd2, BURST_INCR);
    w_beat(32'hC3, 4'hF, 1'b1);
    w_beat(32'hD4, 4'hF, 1'b1);
    drain();

    // read backpressure
    rready = 1'b0;
    push_r(4'd8, 32'h11, RESP_OKAY, 1'b0);
    push_r(4'd8, 32'h22, RESP_OKAY, 1'b1);
    ar_hs(4'd8, 32'h20, 8'd1, 3'd2, BURST_INCR);
    wait_hi(0, "bp_rvalid_rise");
    c0 = ram_en_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rvalid", 32'(rvalid), 1);
      chk("bp_rdata", rdata, 32'h11);
    end
    chk("bp_no_ram_en", 32'(ram_en_cnt - c0), 0);
    @(posedge clk); #1 rready = 1'b1;
    drain();

    // write response backpressure
    bready = 1'b0;
    push_b(4'd9, RESP_OKAY);
    aw_hs(4'd9, 32'h60, 8'd0, 3'd2, BURST_INCR);
    w_beat(32'h99, 4'hF, 1'b1);
    wait_hi(1, "bp_bvalid_rise");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_bvalid", 32'(bvalid), 1);
    end
    @(posedge clk); #1 bready = 1'b1;
    drain();

    // out-of-range address and oversized beat
    c0 = ram_en_cnt;
    push_r(4'd10, 32'h0, RESP_SLVERR, 1'b1);
    ar_hs(4'd10, 32'h0010_0000, 8'd0, 3'd2, BURST_INCR);
    drain();
    push_r(4'd11, 32'h0, RESP_SLVERR, 1'b0);
    push_r(4'd11, 32'h0, RESP_SLVERR, 1'b1);
    ar_hs(4'd11, 32'h10, 8'd1, 3'd3, BURST_INCR);
    drain();
    chk("err_no_ram_en", 32'(ram_en_cnt - c0), 0);

    // reset while a read response is pending
    rready = 1'b0;
    ar_hs(4'd12, 32'h10, 8'd0, 3'd2, BURST_INCR);
    wait_hi(0, "mid_rvalid_rise");
    @(posedge clk); #1 resetn = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_rvalid", 32'(rvalid), 0);
    chk("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
    resetn = 1'b1; rready = 1'b1;
    @(posedge clk); #1;

    // arbitration: write first after reset, then read, then the next write
    arid = 4'd5; araddr = 32'h10; arlen = 8'd0; arsize = 3'd2; arburst = BURST_INCR; arvalid = 1'b1;
    awid = 4'd6; awaddr = 32'h50; awlen = 8'd0; awsize = 3'd2; awburst = BURST_INCR; awvalid = 1'b1;
    push_b(4'd6, RESP_OKAY);
    @(negedge clk);
    chk("arb1_awready", 32'(awready), 1);
    chk("arb1_arready", 32'(arready), 0);
    @(posedge clk); #1 awvalid = 1'b0;
    w_beat(32'h55, 4'hF, 1'b1);
    wait_hi(1, "arb1_bvalid");
    @(posedge clk); #1;
    awid = 4'd7; awaddr = 32'h54; awvalid = 1'b1;
    push_r(4'd5, 32'hDEADBEEF, RESP_OKAY, 1'b1);
    @(negedge clk);
    chk("arb2_arready", 32'(arready), 1);
    chk("arb2_awready", 32'(awready), 0);
    @(posedge clk); #1 arvalid = 1'b0;
    drain();
    push_b(4'd7, RESP_OKAY);
    wait_hi(3, "arb3_awready");
    @(posedge clk); #1 awvalid = 1'b0;
    w_beat(32'h77, 4'hF, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
